// File: rtl/ram_dual_port_pipelined.sv
// True dual-port RAM with byte-enabled writes, write-first cross-port forwarding and range checks.
// Define RAM_PARITY_EN to store one even-parity bit per byte and report per-byte mismatches on read.
module ram_dual_port_pipelined #(
    parameter int    ADDRESS_WIDTH = 16,
    parameter int    DATA_WIDTH    = 16,
    parameter int    MEMORY_DEPTH  = 64,
    parameter int    READ_LATENCY  = 1,
    parameter string INIT_FILE     = ""
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_enable,
    input  logic                     a_rw,
    input  logic [ADDRESS_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0]    a_data_in,
    input  logic [DATA_WIDTH/8-1:0]  a_byte_enable,
    output logic [DATA_WIDTH-1:0]    a_data_out,
    output logic                     a_rvalid,
    output logic                     a_range_error,
`ifdef RAM_PARITY_EN
    output logic [DATA_WIDTH/8-1:0]  a_parity_error,
    output logic [DATA_WIDTH/8-1:0]  b_parity_error,
`endif
    input  logic                     b_enable,
    input  logic                     b_rw,
    input  logic [ADDRESS_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0]    b_data_in,
    input  logic [DATA_WIDTH/8-1:0]  b_byte_enable,
    output logic [DATA_WIDTH-1:0]    b_data_out,
    output logic                     b_rvalid,
    output logic                     b_range_error
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);
`ifdef RAM_PARITY_EN
    localparam int EW = DATA_WIDTH + NB;
`else
    localparam int EW = DATA_WIDTH;
`endif

    generate
        if ((DATA_WIDTH % 8) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2) ||
            (MEMORY_DEPTH < 1) || (IW > ADDRESS_WIDTH)) begin : g_bad_params
            $error("ram_dual_port_pipelined: illegal parameter combination");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
`ifdef RAM_PARITY_EN
    logic [NB-1:0]         par_q [MEMORY_DEPTH];
`endif

    // Both ports are handled as index 0 (A) and 1 (B); a request during reset is dropped here.
    logic [1:0]               reqEn;
    logic [1:0]               reqWr;
    logic [1:0]               inRange;
    logic [1:0]               wrEn;
    logic [1:0]               rdEn;
    logic [ADDRESS_WIDTH-1:0] reqAddr [2];
    logic [DATA_WIDTH-1:0]    reqData [2];
    logic [NB-1:0]            reqBe   [2];
    logic [IW-1:0]            reqIdx  [2];

    always_comb begin
        reqEn      = {b_enable, a_enable} & {2{~reset}};
        reqWr      = {b_rw, a_rw};
        reqAddr[0] = a_address;
        reqAddr[1] = b_address;
        reqData[0] = a_data_in;
        reqData[1] = b_data_in;
        reqBe[0]   = a_byte_enable;
        reqBe[1]   = b_byte_enable;
        inRange    = '0;
        for (int p = 0; p < 2; p++) begin
            inRange[p] = ({1'b0, reqAddr[p]} < DEPTH_LIMIT);
            reqIdx[p]  = reqAddr[p][IW-1:0];
        end
        wrEn = reqEn & reqWr & inRange;
        rdEn = reqEn & ~reqWr;
    end

    // B is applied before A so that A's data wins on bytes both ports enable.
    always_ff @(posedge clock) begin
        for (int p = 1; p >= 0; p--) begin
            if (wrEn[p]) begin
                for (int i = 0; i < NB; i++) begin
                    if (reqBe[p][i]) begin
                        mem_q[reqIdx[p]][8*i +: 8] <= reqData[p][8*i +: 8];
`ifdef RAM_PARITY_EN
                        par_q[reqIdx[p]][i] <= ^reqData[p][8*i +: 8];
`endif
                    end
                end
            end
        end
    end

    // Read word per port: bytes the other port writes this cycle are forwarded (and so carry
    // their own fresh parity); everything else comes from the array. Out-of-range reads give 0.
    logic [DATA_WIDTH-1:0] rdData   [2];
    logic [EW-1:0]         rdWord_d [2];
`ifdef RAM_PARITY_EN
    logic [NB-1:0]         rdPerr   [2];
`endif

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = '0;
`ifdef RAM_PARITY_EN
            rdPerr[p] = '0;
`endif
            if (inRange[p]) begin
                for (int i = 0; i < NB; i++) begin
                    if (wrEn[1-p] && (reqAddr[1-p] == reqAddr[p]) && reqBe[1-p][i]) begin
                        rdData[p][8*i +: 8] = reqData[1-p][8*i +: 8];
                    end else begin
                        rdData[p][8*i +: 8] = mem_q[reqIdx[p]][8*i +: 8];
`ifdef RAM_PARITY_EN
                        rdPerr[p][i] = (^mem_q[reqIdx[p]][8*i +: 8]) ^ par_q[reqIdx[p]][i];
`endif
                    end
                end
            end
`ifdef RAM_PARITY_EN
            rdWord_d[p] = {rdPerr[p], rdData[p]};
`else
            rdWord_d[p] = rdData[p];
`endif
        end
    end

    logic [1:0]    finValid;
    logic [1:0]    finRerr;
    logic [EW-1:0] finWord [2];

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [1:0]    s1Valid_q;
            logic [1:0]    s1Rerr_q;
            logic [EW-1:0] s1Word_q [2];

            always_ff @(posedge clock) begin
                if (reset) begin
                    s1Valid_q   <= '0;
                    s1Rerr_q    <= '0;
                    s1Word_q[0] <= '0;
                    s1Word_q[1] <= '0;
                end else begin
                    s1Valid_q   <= rdEn;
                    s1Rerr_q    <= rdEn & ~inRange;
                    s1Word_q[0] <= rdWord_d[0];
                    s1Word_q[1] <= rdWord_d[1];
                end
            end

            always_comb begin
                finValid   = s1Valid_q;
                finRerr    = s1Rerr_q;
                finWord[0] = s1Word_q[0];
                finWord[1] = s1Word_q[1];
            end
        end else begin : g_lat1
            always_comb begin
                finValid   = rdEn;
                finRerr    = rdEn & ~inRange;
                finWord[0] = rdWord_d[0];
                finWord[1] = rdWord_d[1];
            end
        end
    endgenerate

    // Output stage: data holds between responses, while strobes and parity flags only pulse.
    // Write range errors skip the read pipeline and always report the cycle after acceptance.
    logic [1:0]    rvalid_q;
    logic [1:0]    rangeErr_q;
    logic [EW-1:0] word_q [2];

    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_q   <= '0;
            rangeErr_q <= '0;
            word_q[0]  <= '0;
            word_q[1]  <= '0;
        end else begin
            rvalid_q   <= finValid;
            rangeErr_q <= finRerr | (reqEn & reqWr & ~inRange);
            for (int p = 0; p < 2; p++) begin
                if (finValid[p]) begin
                    word_q[p] <= finWord[p];
                end
`ifdef RAM_PARITY_EN
                else begin
                    word_q[p][EW-1 -: NB] <= '0;
                end
`endif
            end
        end
    end

    assign a_data_out    = word_q[0][DATA_WIDTH-1:0];
    assign b_data_out    = word_q[1][DATA_WIDTH-1:0];
    assign a_rvalid      = rvalid_q[0];
    assign b_rvalid      = rvalid_q[1];
    assign a_range_error = rangeErr_q[0];
    assign b_range_error = rangeErr_q[1];
`ifdef RAM_PARITY_EN
    assign a_parity_error = word_q[0][EW-1 -: NB];
    assign b_parity_error = word_q[1][EW-1 -: NB];
`endif

endmodule

// File: tb/tb_ram_dual_port_pipelined.sv
// Scoreboard bench for ram_dual_port_pipelined: one instance per read latency, shared stimulus.
// Lanes: 0 = latency-1 port A, 1 = latency-1 port B, 2 = latency-2 port A, 3 = latency-2 port B.
module tb_ram_dual_port_pipelined;

    typedef struct {
        int          lane;
        int          due;
        logic [15:0] data;
        logic        rv;
        logic        re;
        logic [1:0]  pe;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        aEn, aRw, bEn, bRw;
    logic [15:0] aAddr, aDin, bAddr, bDin;
    logic [1:0]  aBe, bBe;

    logic [15:0] dout [4];
    logic [3:0]  rv;
    logic [3:0]  re;
`ifdef RAM_PARITY_EN
    logic [1:0]  perr [4];
`endif

    exp_t        sbQ[$];
    logic [15:0] refMem   [64];
    logic [1:0]  perrMask [64];
    logic [15:0] lastData [4];
    bit          rstAt    [8192];
    bit          started = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        mV, mE;
    logic [1:0]  mP;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    ram_dual_port_pipelined #(.READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .a_enable(aEn), .a_rw(aRw), .a_address(aAddr), .a_data_in(aDin), .a_byte_enable(aBe),
        .a_data_out(dout[0]), .a_rvalid(rv[0]), .a_range_error(re[0]),
`ifdef RAM_PARITY_EN
        .a_parity_error(perr[0]), .b_parity_error(perr[1]),
`endif
        .b_enable(bEn), .b_rw(bRw), .b_address(bAddr), .b_data_in(bDin), .b_byte_enable(bBe),
        .b_data_out(dout[1]), .b_rvalid(rv[1]), .b_range_error(re[1])
    );

    ram_dual_port_pipelined #(.READ_LATENCY(2)) dut2 (
        .clock(clock), .reset(reset),
        .a_enable(aEn), .a_rw(aRw), .a_address(aAddr), .a_data_in(aDin), .a_byte_enable(aBe),
        .a_data_out(dout[2]), .a_rvalid(rv[2]), .a_range_error(re[2]),
`ifdef RAM_PARITY_EN
        .a_parity_error(perr[2]), .b_parity_error(perr[3]),
`endif
        .b_enable(bEn), .b_rw(bRw), .b_address(bAddr), .b_data_in(bDin), .b_byte_enable(bBe),
        .b_data_out(dout[3]), .b_rvalid(rv[3]), .b_range_error(re[3])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model of one accepted edge: computes read results against pre-edge contents,
    // queues them for both latencies, then applies writes (B first, A wins).
    task automatic modelAccept(input int e);
        logic        pEn [2];
        logic        pRw [2];
        logic        inR [2];
        logic [15:0] pAddr [2];
        logic [15:0] pDin [2];
        logic [1:0]  pBe [2];
        logic [15:0] val;
        logic [1:0]  fwd, pe;
        int          o;
        pEn[0] = aEn;   pEn[1] = bEn;
        pRw[0] = aRw;   pRw[1] = bRw;
        pAddr[0] = aAddr; pAddr[1] = bAddr;
        pDin[0] = aDin; pDin[1] = bDin;
        pBe[0] = aBe;   pBe[1] = bBe;
        for (int p = 0; p < 2; p++) inR[p] = (pAddr[p] < 16'd64);
        for (int p = 0; p < 2; p++) begin
            o = 1 - p;
            if (pEn[p] && !pRw[p]) begin
                val = 16'h0000;
                pe  = 2'b00;
                fwd = 2'b00;
                if (inR[p]) begin
                    val = refMem[pAddr[p][5:0]];
                    if (pEn[o] && pRw[o] && (pAddr[o] == pAddr[p])) fwd = pBe[o];
                    for (int i = 0; i < 2; i++) if (fwd[i]) val[8*i +: 8] = pDin[o][8*i +: 8];
                    pe = perrMask[pAddr[p][5:0]] & ~fwd;
                end
                sbQ.push_back('{lane: p,     due: e,     data: val, rv: 1'b1, re: !inR[p], pe: pe});
                sbQ.push_back('{lane: p + 2, due: e + 1, data: val, rv: 1'b1, re: !inR[p], pe: pe});
            end else if (pEn[p] && pRw[p] && !inR[p]) begin
                sbQ.push_back('{lane: p,     due: e, data: 16'h0, rv: 1'b0, re: 1'b1, pe: 2'b00});
                sbQ.push_back('{lane: p + 2, due: e, data: 16'h0, rv: 1'b0, re: 1'b1, pe: 2'b00});
            end
        end
        for (int p = 1; p >= 0; p--) begin
            if (pEn[p] && pRw[p] && inR[p]) begin
                for (int i = 0; i < 2; i++) begin
                    if (pBe[p][i]) begin
                        refMem[pAddr[p][5:0]][8*i +: 8] = pDin[p][8*i +: 8];
                        perrMask[pAddr[p][5:0]][i] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Drives one cycle of requests on both ports; under reset nothing is accepted and
    // anything still in flight is dropped from the expectations.
    task automatic applyStimulus(input logic iAEn, input logic iARw, input logic [15:0] iAAddr,
                                 input logic [15:0] iADin, input logic [1:0] iABe,
                                 input logic iBEn, input logic iBRw, input logic [15:0] iBAddr,
                                 input logic [15:0] iBDin, input logic [1:0] iBBe);
        int e;
        aEn = iAEn; aRw = iARw; aAddr = iAAddr; aDin = iADin; aBe = iABe;
        bEn = iBEn; bRw = iBRw; bAddr = iBAddr; bDin = iBDin; bBe = iBBe;
        e = cyc + 1;
        if (reset) begin
            rstAt[e] = 1'b1;
            for (int k = sbQ.size() - 1; k >= 0; k--) if (sbQ[k].due >= e) sbQ.delete(k);
        end else begin
            modelAccept(e);
        end
        @(posedge clock);
        #1;
        aEn = 1'b0;
        bEn = 1'b0;
    endtask

    task automatic writeA(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        applyStimulus(1'b1, 1'b1, a, d, be, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    endtask

    task automatic writeB(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b1, a, d, be);
    endtask

    task automatic readA(input logic [15:0] a);
        applyStimulus(1'b1, 1'b0, a, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    endtask

    task automatic readB(input logic [15:0] a);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0, a, 16'h0, 2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    // Monitor: pops every expectation due this cycle and checks strobes, data and flags.
    always @(negedge clock) begin
        if (cyc > 0 && cyc < 8192 && rstAt[cyc]) started = 1'b1;
        if (started && cyc < 8192) begin
            for (int lane = 0; lane < 4; lane++) begin
                mV = 1'b0;
                mE = 1'b0;
                mP = 2'b00;
                if (rstAt[cyc]) lastData[lane] = 16'h0;
                for (int k = sbQ.size() - 1; k >= 0; k--) begin
                    if (sbQ[k].lane == lane && sbQ[k].due == cyc) begin
                        if (sbQ[k].rv) begin
                            mV = 1'b1;
                            lastData[lane] = sbQ[k].data;
                            mP = sbQ[k].pe;
                        end
                        if (sbQ[k].re) mE = 1'b1;
                        sbQ.delete(k);
                    end
                end
                checkOutput($sformatf("lane%0d rvalid", lane), {31'b0, rv[lane]}, {31'b0, mV});
                checkOutput($sformatf("lane%0d range_error", lane), {31'b0, re[lane]}, {31'b0, mE});
                checkOutput($sformatf("lane%0d data_out", lane), {16'b0, dout[lane]}, {16'b0, lastData[lane]});
`ifdef RAM_PARITY_EN
                checkOutput($sformatf("lane%0d parity_error", lane), {30'b0, perr[lane]}, {30'b0, mP});
`endif
            end
        end
    end

    initial begin
        aEn = 1'b0; aRw = 1'b0; aAddr = 16'h0; aDin = 16'h0; aBe = 2'b00;
        bEn = 1'b0; bRw = 1'b0; bAddr = 16'h0; bDin = 16'h0; bBe = 2'b00;
        for (int i = 0; i < 64; i++) begin
            refMem[i]   = 16'h0;
            perrMask[i] = 2'b00;
        end
        for (int i = 0; i < 4; i++) lastData[i] = 16'h0;

        doReset(2);
        for (int i = 0; i < 10; i++) writeA(16'(i), (16'(i) * 16'h0101) ^ 16'h5A3C, 2'b11);
        for (int i = 10; i < 20; i++) writeB(16'(i), (16'(i) * 16'h0303) ^ 16'hC3A5, 2'b11);

        writeA(16'd5, 16'hBEEF, 2'b11);
        readA(16'd5);
        idle(2);

        writeA(16'd3, 16'h1234, 2'b11);
        writeA(16'd3, 16'hABCD, 2'b10);
        readB(16'd3);
        writeB(16'd3, 16'hFFFF, 2'b00);
        readA(16'd3);
        idle(2);

        applyStimulus(1'b1, 1'b1, 16'd7, 16'h1111, 2'b01, 1'b1, 1'b1, 16'd7, 16'h2222, 2'b11);
        readA(16'd7);
        applyStimulus(1'b1, 1'b1, 16'd8, 16'h3344, 2'b10, 1'b1, 1'b1, 16'd8, 16'h5566, 2'b11);
        readB(16'd8);
        idle(2);

        writeA(16'd9, 16'h0000, 2'b11);
        applyStimulus(1'b1, 1'b1, 16'd9, 16'h5A5A, 2'b11, 1'b1, 1'b0, 16'd9, 16'h0, 2'b00);
        applyStimulus(1'b1, 1'b0, 16'd9, 16'h0, 2'b00, 1'b1, 1'b1, 16'd9, 16'hC3C3, 2'b01);
        applyStimulus(1'b1, 1'b0, 16'd9, 16'h0, 2'b00, 1'b1, 1'b0, 16'd9, 16'h0, 2'b00);
        idle(2);

        for (int i = 0; i < 6; i++) readA(16'(i));
        readA(16'd64);
        writeB(16'd100, 16'hDEAD, 2'b11);
        readB(16'hFFFF);
        applyStimulus(1'b1, 1'b0, 16'd63, 16'h0, 2'b00, 1'b1, 1'b1, 16'd64, 16'h7777, 2'b11);
        idle(3);

        readA(16'd5);
        doReset(1);
        idle(2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'd5, 16'h0000, 2'b11, 1'b1, 1'b0, 16'd5, 16'h0, 2'b00);
        reset = 1'b0;
        readA(16'd5);
        idle(3);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 16'(64 + $urandom_range(0, 3)) : 16'($urandom_range(0, 7)),
                          16'($urandom), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 16'(64 + $urandom_range(0, 3)) : 16'($urandom_range(0, 7)),
                          16'($urandom), 2'($urandom_range(0, 3)));
        end
        idle(3);

`ifdef RAM_PARITY_EN
        dut1.mem_q[2][0] = ~dut1.mem_q[2][0];
        dut2.mem_q[2][0] = ~dut2.mem_q[2][0];
        refMem[2][0]     = ~refMem[2][0];
        perrMask[2]      = 2'b01;
        readA(16'd2);
        applyStimulus(1'b1, 1'b0, 16'd2, 16'h0, 2'b00, 1'b1, 1'b1, 16'd2, 16'h00A5, 2'b01);
        readB(16'd2);
        idle(3);
`endif

        idle(4);
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
